// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share
// one fixed-latency memory. Grants alternate on contention, every access takes
// LATENCY busy cycles plus a one-cycle response, and d_err flags any grant
// where the data port asserted read and write together.
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,   // active-high despite the name
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_rd,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_en,
    output logic                 m_we,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 i_stall,
    output logic                 d_stall,
    output logic                 d_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_last_d;    // 1: last completed grant went to D
    logic                 r_sel_d;     // port owning the current access
    logic                 r_m_en;
    logic                 r_m_we;
    logic [WORD_SIZE-1:0] r_m_addr;
    logic [WORD_SIZE-1:0] r_m_wdata;
    logic [WORD_SIZE-1:0] r_i_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;
    logic                 r_i_ready;
    logic                 r_d_ready;
    logic                 r_d_err;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_d;
    logic w_grant_i;

    assign w_i_pend  = i_req;
    assign w_d_pend  = d_rd | d_wr;
    // On a tie the port that did not win last time goes first.
    assign w_grant_d = w_d_pend && (!w_i_pend || !r_last_d);
    assign w_grant_i = w_i_pend && !w_grant_d;

    // Arbitration FSM with all outputs registered; address/data latches
    // double as the memory-side outputs.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_last_d  <= 1'b0;
            r_sel_d   <= 1'b0;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= BUSY_D;
                        r_sel_d   <= 1'b1;
                        r_cnt     <= CNT_LOAD;
                        r_m_en    <= 1'b1;
                        r_m_we    <= d_wr;     // rd+wr together resolves to a write
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                        if (d_rd && d_wr) begin
                            r_d_err <= 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_state  <= BUSY_I;
                        r_sel_d  <= 1'b0;
                        r_cnt    <= CNT_LOAD;
                        r_m_en   <= 1'b1;
                        r_m_we   <= 1'b0;
                        r_m_addr <= i_addr;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        r_m_en  <= 1'b0;
                        r_m_we  <= 1'b0;
                        if (r_state == BUSY_I) begin
                            r_i_rdata <= m_rdata;
                            r_i_ready <= 1'b1;
                        end else begin
                            // Write responses leave d_rdata untouched.
                            if (!r_m_we) begin
                                r_d_rdata <= m_rdata;
                            end
                            r_d_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state  <= IDLE;
                    r_last_d <= r_sel_d;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata = r_i_rdata;
    assign i_ready = r_i_ready;
    assign d_rdata = r_d_rdata;
    assign d_ready = r_d_ready;
    assign m_en    = r_m_en;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign d_err   = r_d_err;

    // Stalls follow the live request; forced low while reset is held.
    assign i_stall = i_req & ~r_i_ready & ~reset_n;
    assign d_stall = (d_rd | d_wr) & ~r_d_ready & ~reset_n;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LATENCY=4 instance against a small memory
// model that only presents valid read data in the final busy cycle, and a
// LATENCY=1 instance for back-to-back throughput.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        i_ready, d_ready, m_en, m_we, i_stall, d_stall, d_err;

    logic        i_req2;
    logic [15:0] i_addr2, i_rdata2, d_rdata2, m_addr2, m_wdata2, m_rdata2;
    logic        i_ready2, d_ready2, m_en2, m_we2, i_stall2, d_stall2, d_err2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .i_stall(i_stall), .d_stall(d_stall), .d_err(d_err)
    );

    mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(rst),
        .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_ready(i_ready2),
        .d_rd(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_rdata(d_rdata2), .d_ready(d_ready2),
        .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2),
        .m_rdata(m_rdata2), .i_stall(i_stall2), .d_stall(d_stall2), .d_err(d_err2)
    );

    // Memory model: word at a is {a, ~a} except 0x10 = 0xABCD; read data is
    // only valid in the LAT-th consecutive enable cycle, 0xDEAD otherwise.
    logic [15:0] mem [0:255];
    logic        mem_inited = 1'b0;
    int          m_en_cnt   = 0;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int a = 0; a < 256; a++) mem[a] <= {8'(a), ~8'(a)};
            mem[8'h10] <= 16'hABCD;
            mem_inited <= 1'b1;
        end else if (m_en && m_we) begin
            mem[m_addr[7:0]] <= m_wdata;
        end
        m_en_cnt <= m_en ? m_en_cnt + 1 : 0;
    end

    assign m_rdata  = (m_en && m_en_cnt == LAT - 1) ? mem[m_addr[7:0]] : 16'hDEAD;
    assign m_rdata2 = m_en2 ? (m_addr2 ^ 16'h5555) : 16'hDEAD;

    // Scoreboard of expected ready pulses.
    typedef struct {
        logic        is_d;
        logic        chk_data;
        logic [15:0] data;
        int          exp_cyc;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_e;

    typedef struct {
        int          kind;      // 0 fetch, 1 d read, 2 d write, 3 d read+write
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          drop_at;   // cycle index to drop the request, -1 never
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Pops the scoreboard on every ready pulse of the LATENCY=4 instance.
    always @(negedge clk) begin
        if (!rst && (i_ready || d_ready)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got i_ready=%0b d_ready=%0b expected none (cyc %0d)",
                         i_ready, d_ready, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("ready_port", {31'd0, d_ready}, {31'd0, mon_e.is_d});
                chk("ready_cycle", cyc, mon_e.exp_cyc);
                if (mon_e.chk_data)
                    chk("rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.data);
            end
        end
    end

    // Drives one access from an IDLE cycle and checks it cycle by cycle.
    task automatic run_access(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_rd, input int drop_at, input logic exp_err);
        int   t0;
        sb_t  e;
        logic is_d, exp_we, active;
        is_d   = (kind != 0);
        exp_we = (kind == 2 || kind == 3);
        active = 1'b1;
        t0     = cyc;
        if (!is_d) begin
            i_req = 1'b1; i_addr = addr;
        end else begin
            d_addr = addr; d_wdata = wdata;
            d_rd = (kind == 1 || kind == 3);
            d_wr = exp_we;
        end
        e.is_d = is_d; e.chk_data = (kind <= 1); e.data = exp_rd; e.exp_cyc = t0 + LAT + 1;
        sbq.push_back(e);
        for (int j = 0; j <= LAT + 1; j++) begin
            @(negedge clk);
            if (j >= 1 && j <= LAT) begin
                chk("m_en_busy", {31'd0, m_en}, 32'd1);
                chk("m_we", {31'd0, m_we}, {31'd0, exp_we});
                chk("m_addr", {16'd0, m_addr}, {16'd0, addr});
                if (exp_we) chk("m_wdata", {16'd0, m_wdata}, {16'd0, wdata});
            end else begin
                chk("m_en_off", {31'd0, m_en}, 32'd0);
            end
            if (is_d) chk("d_stall", {31'd0, d_stall}, {31'd0, active && j != LAT + 1});
            else      chk("i_stall", {31'd0, i_stall}, {31'd0, active && j != LAT + 1});
            if (j == LAT + 1) chk("ready", {31'd0, is_d ? d_ready : i_ready}, 32'd1);
            if (j == drop_at) begin
                #1;
                i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
                active = 1'b0;
            end
        end
        chk("d_err", {31'd0, d_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0 (cyc %0d)", sbq.size(), cyc);
            sbq.delete();
        end
        $display("access kind=%0d addr=%h wdata=%h exp=%h t0=%0d", kind, addr, wdata, exp_rd, t0);
    endtask

    initial begin
        int t0;
        sb_t e;

        vecs[0] = '{0, 16'h0010, 16'h0000, 16'hABCD, -1};
        vecs[1] = '{1, 16'h0030, 16'h0000, 16'h30CF, -1};
        vecs[2] = '{2, 16'h0020, 16'h1234, 16'h0000, -1};
        vecs[3] = '{1, 16'h0020, 16'h0000, 16'h1234, -1};
        vecs[4] = '{0, 16'h0020, 16'h0000, 16'h1234, -1};
        vecs[5] = '{0, 16'h00F0, 16'h0000, 16'hF00F,  2};
        vecs[6] = '{2, 16'h0040, 16'h0BEE, 16'h0000, -1};
        vecs[7] = '{0, 16'h0040, 16'h0000, 16'h0BEE, -1};
        vecs[8] = '{1, 16'h0001, 16'h0000, 16'h01FE,  3};

        // Reset held with both requesters already asserting.
        rst = 1'b1;
        i_req = 1'b1; i_addr = 16'h0010;
        d_rd = 1'b1; d_wr = 1'b0; d_addr = 16'h0030; d_wdata = 16'h0000;
        i_req2 = 1'b0; i_addr2 = 16'h0100;
        repeat (3) @(negedge clk);
        chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_m_en",    {31'd0, m_en}, 32'd0);
        chk("rst_m_addr",  {16'd0, m_addr}, 32'd0);
        chk("rst_rdata",   {i_rdata, d_rdata}, 32'd0);
        chk("rst_stalls",  {30'd0, i_stall, d_stall}, 32'd0);
        chk("rst_d_err",   {31'd0, d_err}, 32'd0);

        // Contention from reset: D, I, D, I, each LAT+2 cycles apart.
        @(posedge clk); #1;
        rst = 1'b0;
        t0  = cyc;
        for (int k = 0; k < 4; k++) begin
            e.is_d     = (k % 2 == 0);
            e.chk_data = 1'b1;
            e.data     = e.is_d ? 16'h30CF : 16'hABCD;
            e.exp_cyc  = t0 + LAT + 1 + k * (LAT + 2);
            sbq.push_back(e);
        end
        repeat (4 * (LAT + 2)) @(posedge clk);
        #1;
        i_req = 1'b0; d_rd = 1'b0;
        chk("contention_done", sbq.size(), 32'd0);
        sbq.delete();
        $display("contention rounds D,I,D,I t0=%0d", t0);

        // Table of single accesses.
        for (int v = 0; v < 9; v++)
            run_access(vecs[v].kind, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata,
                       vecs[v].drop_at, 1'b0);

        // Read and write together: performed as a write, error sticks.
        run_access(3, 16'h0050, 16'h7777, 16'h0000, -1, 1'b1);
        run_access(1, 16'h0050, 16'h0000, 16'h7777, -1, 1'b1);

        // Reset in the middle of a data read (cnt == 2).
        d_addr = 16'h0030; d_rd = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy", {31'd0, m_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_m_en",   {31'd0, m_en}, 32'd0);
        chk("abort_m_addr", {16'd0, m_addr}, 32'd0);
        chk("abort_d_err",  {31'd0, d_err}, 32'd0);
        chk("abort_rdata",  {i_rdata, d_rdata}, 32'd0);
        chk("abort_stall",  {31'd0, d_stall}, 32'd0);
        d_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("abort_no_ready", {30'd0, d_ready, m_en}, 32'd0);
        end
        @(posedge clk); #1;
        run_access(1, 16'h0030, 16'h0000, 16'h30CF, -1, 1'b0);

        // LATENCY=1 instance with a continuously held fetch request.
        i_req2 = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            chk("lat1_ready", {31'd0, i_ready2}, {31'd0, (j >= 2) && ((j - 2) % 3 == 0)});
            if ((j >= 2) && ((j - 2) % 3 == 0))
                chk("lat1_rdata", {16'd0, i_rdata2}, 32'h5455);
        end
        i_req2 = 1'b0;
        $display("latency1 back-to-back fetches checked");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
